fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the pipelined core's Fetch/Decode boundary.
- Issues in-order word requests to instruction memory through a valid/ready request channel and an in-order response channel.
- Buffers the returned instructions with their PCs in a small FIFO and presents the FIFO head to the core.
- Honours the hazard unit's StallF and the Execute-stage redirect (PCSrcE/PCTargetE), and discards stale in-flight responses after a redirect.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, at least 2.
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Reset  in  1  synchronous reset, active-low.
- o_MemReqValid  out  1  request valid.
- i_MemReqReady  in  1  memory accepts the request.
- o_MemReqAddr  out  XLEN  word-aligned fetch address.
- i_MemRspValid  in  1  response valid; one per accepted request, in order, at least 1 cycle after acceptance.
- i_MemRspData  in  XLEN  instruction word.
- o_InstrValid  out  1  FIFO head valid.
- o_InstrF  out  XLEN  head instruction.
- o_PCF  out  XLEN  head PC.
- o_PCPlus4F  out  XLEN  o_PCF + 4.
- i_StallF  in  1  core holds the head; no pop.
- i_PCSrcE  in  1  redirect request.
- i_PCTargetE  in  XLEN  redirect target.

Behaviour:
- Reset (i_Reset=0 at an edge):
  - FIFO empty; r_FetchPC=RESET_PC; outstanding=0; drop=0; state=RUN.
  - o_MemReqValid=0 and o_InstrValid=0 while reset is held.
  - o_InstrF, o_PCF, o_PCPlus4F read as 0 when the FIFO is empty.
- Reset mid-operation: all in-flight responses are forgotten; the memory must also be reset.
- Request issue:
  - o_MemReqValid = state RUN && !i_PCSrcE && (count + outstanding < DEPTH).
  - o_MemReqAddr = r_FetchPC.
  - On accept (valid && ready): r_FetchPC += 4 with XLEN wrap-around, and outstanding += 1.
  - The address and valid stay stable while ready is low, unless a redirect occurs.
- Response:
  - outstanding -= 1 on every i_MemRspValid.
  - If drop > 0: the word is discarded and drop -= 1.
  - Otherwise the word is pushed with its PC from the r_RspPC tracker, which increments by 4 per accepted response.
  - Credit rule guarantees there is never a push to a full FIFO.
- Pop: when o_InstrValid && !i_StallF && !i_PCSrcE.
- Push and pop may occur in the same cycle; count is unchanged.
- Latency: a response in cycle N makes o_InstrValid visible in cycle N+1. The head is registered with no combinational path from i_MemRsp* to o_Instr*.
- Redirect (i_PCSrcE=1):
  - FIFO cleared.
  - r_FetchPC and r_RspPC set to i_PCTargetE.
  - drop = outstanding after this cycle's response is accounted, i.e. outstanding − i_MemRspValid. A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - Next state: DRAIN if the new drop > 0, else RUN.
  - Redirect overrides pop and push in the same cycle.
- FSM:
  - RUN: normal operation.
  - DRAIN: no new requests; responses discarded. Transition to RUN on the cycle drop reaches 0, with requests resuming the next cycle.
  - A redirect while in DRAIN reloads the target PC and recomputes drop; the state stays DRAIN if drop > 0.
- Misaligned i_PCTargetE: bits [1:0] are forced to 0.
- Widths: count and outstanding are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- Defined: adds output ports o_BubbleCnt (32) and o_RedirectCnt (32).
  - o_BubbleCnt counts cycles with !o_InstrValid && !i_StallF, outside reset.
  - o_RedirectCnt counts cycles with i_PCSrcE=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, ready=1, 1-cycle response latency → requests to 0x0, 0x4, 0x8, 0xC on consecutive cycles; o_InstrValid first rises 2 cycles after the first accept with PCF=0x0 and PCPlus4F=0x4.
- i_StallF=1, memory always ready → at most 4 outstanding + buffered; requests stop when count+outstanding=4; head stays PCF=0x0 until the stall drops.
- 3 requests outstanding (latency 5), redirect to 0x100 → FIFO empty next cycle; state DRAIN, drop=3; the 3 responses are discarded; first new request at 0x100 the cycle after drop reaches 0; the instruction at 0x100 is delivered.
- Redirect coincident with a response and with i_StallF=0 → that response is dropped, no pop counted, and o_InstrValid=0 the next cycle.
- i_MemReqReady held low 3 cycles → o_MemReqAddr held at 0x8 and valid stays high; after acceptance, subsequent PCs are contiguous.
- Reset asserted while 2 requests are outstanding → outputs return to reset values the next cycle; fetch restarts at RESET_PC. With FETCH_QUEUE_PERF_EN, o_BubbleCnt and o_RedirectCnt read 0.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch stage that sits in front of the core's Fetch/Decode
//   boundary. It issues in-order word fetches to instruction memory, buffers
//   the returned words together with their PCs in a small FIFO, and presents
//   the FIFO head to the core. An Execute-stage redirect flushes the FIFO,
//   reloads the fetch PC and discards responses that are still in flight.
//
//   Handshakes: a request transfers on a rising edge where o_MemReqValid and
//   i_MemReqReady are both high. Once raised, valid and address are held
//   until that transfer, unless a redirect intervenes. Memory returns exactly
//   one i_MemRspValid pulse per accepted request, in order, no earlier than
//   the cycle after acceptance; there is no backpressure on responses.
//
//   Ports:
//     i_Clk, i_Reset        clock, synchronous active-low reset
//     o_MemReqValid/Addr    fetch request (word-aligned address)
//     i_MemReqReady         memory accepts the request
//     i_MemRspValid/Data    in-order instruction word returns
//     o_InstrValid          FIFO head valid
//     o_InstrF/PCF/PCPlus4F head instruction, its PC and PC+4 (0 when empty)
//     i_StallF              core holds the head
//     i_PCSrcE/i_PCTargetE  redirect request and target
//
//   Optional: define FETCH_QUEUE_PERF_EN to add o_BubbleCnt and
//   o_RedirectCnt, saturating 32-bit event counters.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    output logic            o_MemReqValid,
    input  logic            i_MemReqReady,
    output logic [XLEN-1:0] o_MemReqAddr,
    input  logic            i_MemRspValid,
    input  logic [XLEN-1:0] i_MemRspData,
    output logic            o_InstrValid,
    output logic [XLEN-1:0] o_InstrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F,
    input  logic            i_StallF,
    input  logic            i_PCSrcE,
    input  logic [XLEN-1:0] i_PCTargetE
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     o_BubbleCnt,
    output logic [31:0]     o_RedirectCnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          r_State;
    state_t          w_StateNext;
    logic [CW-1:0]   r_Count;
    logic [CW-1:0]   r_Outstanding;
    logic [CW-1:0]   r_Drop;
    logic [CW-1:0]   w_DropNext;
    logic [CW-1:0]   w_OutstandingNext;
    logic [PW-1:0]   r_WrPtr;
    logic [PW-1:0]   r_RdPtr;
    logic [XLEN-1:0] r_FetchPC;
    logic [XLEN-1:0] r_RspPC;
    logic [XLEN-1:0] r_InstrMem [DEPTH];
    logic [XLEN-1:0] r_PCMem    [DEPTH];

    logic            w_Credit;
    logic            w_Accept;
    logic            w_Discard;
    logic            w_Push;
    logic            w_Pop;
    logic [CW:0]     w_Inflight;
    logic [XLEN-1:0] w_Target;
    logic            w_unused_tgt_lsbs;

    // Buffered plus outstanding words never exceed DEPTH, so every response
    // that is kept always finds a free FIFO slot.
    assign w_Inflight = (CW+1)'(r_Count) + (CW+1)'(r_Outstanding);
    assign w_Credit   = (w_Inflight < DEPTH_W);

    assign w_Target          = {i_PCTargetE[XLEN-1:2], 2'b00};
    assign w_unused_tgt_lsbs = ^i_PCTargetE[1:0];

    // Gating with i_Reset keeps the request low while reset is held.
    assign o_MemReqValid = i_Reset && (r_State == ST_RUN) && !i_PCSrcE && w_Credit;
    assign o_MemReqAddr  = r_FetchPC;
    assign w_Accept      = o_MemReqValid && i_MemReqReady;

    assign w_Discard = i_MemRspValid && (r_Drop != '0);
    assign w_Push    = i_MemRspValid && (r_Drop == '0) && !i_PCSrcE;
    assign w_Pop     = o_InstrValid && !i_StallF && !i_PCSrcE;

    assign w_OutstandingNext = r_Outstanding + CW'(w_Accept) - CW'(i_MemRspValid);

    // Head comes straight from registered storage: a response written at
    // the end of cycle N is first visible in cycle N+1.
    assign o_InstrValid = (r_Count != '0);
    assign o_InstrF     = o_InstrValid ? r_InstrMem[r_RdPtr] : '0;
    assign o_PCF        = o_InstrValid ? r_PCMem[r_RdPtr] : '0;
    assign o_PCPlus4F   = o_InstrValid ? (r_PCMem[r_RdPtr] + XLEN'(4)) : '0;

    // Next-state and drop bookkeeping. A redirect recomputes how many
    // responses are stale: everything outstanding minus the one (if any)
    // returning this cycle, which is itself thrown away.
    always_comb begin
        w_StateNext = r_State;
        w_DropNext  = r_Drop;
        if (i_PCSrcE) begin
            w_DropNext  = r_Outstanding - CW'(i_MemRspValid);
            w_StateNext = (w_DropNext != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (w_Discard) begin
                w_DropNext = r_Drop - 1'b1;
            end
            if ((r_State == ST_DRAIN) && (w_DropNext == '0)) begin
                w_StateNext = ST_RUN;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_State       <= ST_RUN;
            r_Count       <= '0;
            r_Outstanding <= '0;
            r_Drop        <= '0;
            r_WrPtr       <= '0;
            r_RdPtr       <= '0;
            r_FetchPC     <= RESET_PC;
            r_RspPC       <= RESET_PC;
        end else begin
            r_State       <= w_StateNext;
            r_Drop        <= w_DropNext;
            r_Outstanding <= w_OutstandingNext;
            if (i_PCSrcE) begin
                r_FetchPC <= w_Target;
                r_RspPC   <= w_Target;
                r_Count   <= '0;
                r_WrPtr   <= '0;
                r_RdPtr   <= '0;
            end else begin
                if (w_Accept) begin
                    r_FetchPC <= r_FetchPC + XLEN'(4);
                end
                if (w_Push) begin
                    r_RspPC <= r_RspPC + XLEN'(4);
                    r_WrPtr <= r_WrPtr + 1'b1;
                end
                if (w_Pop) begin
                    r_RdPtr <= r_RdPtr + 1'b1;
                end
                case ({w_Push, w_Pop})
                    2'b10:   r_Count <= r_Count + 1'b1;
                    2'b01:   r_Count <= r_Count - 1'b1;
                    default: r_Count <= r_Count;
                endcase
            end
        end
    end

    // Storage needs no reset; r_Count decides what is valid.
    always_ff @(posedge i_Clk) begin
        if (w_Push) begin
            r_InstrMem[r_WrPtr] <= i_MemRspData;
            r_PCMem[r_WrPtr]    <= r_RspPC;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_BubbleCnt;
    logic [31:0] r_RedirectCnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            r_BubbleCnt   <= '0;
            r_RedirectCnt <= '0;
        end else begin
            if (!o_InstrValid && !i_StallF && (r_BubbleCnt != '1)) begin
                r_BubbleCnt <= r_BubbleCnt + 32'd1;
            end
            if (i_PCSrcE && (r_RedirectCnt != '1)) begin
                r_RedirectCnt <= r_RedirectCnt + 32'd1;
            end
        end
    end

    assign o_BubbleCnt   = r_BubbleCnt;
    assign o_RedirectCnt = r_RedirectCnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue: a table of per-cycle vectors for the
//   start-up / stall stream, then hand-written sequences for redirect,
//   ready backpressure and mid-run reset. A small in-order memory model
//   with configurable latency answers requests with data = addr ^ 5A5A_0000.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pcf;
    logic [31:0] pcp4;
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_queue #(
        .DEPTH    (4),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .o_MemReqValid (req_valid),
        .i_MemReqReady (req_ready),
        .o_MemReqAddr  (req_addr),
        .i_MemRspValid (rsp_valid),
        .i_MemRspData  (rsp_data),
        .o_InstrValid  (instr_valid),
        .o_InstrF      (instr),
        .o_PCF         (pcf),
        .o_PCPlus4F    (pcp4),
        .i_StallF      (stall),
        .i_PCSrcE      (pcsrc),
        .i_PCTargetE   (target)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .o_BubbleCnt   (bubble_cnt),
        .o_RedirectCnt (redirect_cnt)
`endif
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mem_lat = 1;
    bit sb_on = 1'b0;

    logic [31:0] addr_q[$];
    int          due_q[$];
    logic [31:0] exp_q[$];

    logic        s_rv;
    logic        s_iv;
    logic        s_acc;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_p4;
    logic [31:0] s_instr;

    typedef struct {
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs and the memory response at the negedge,
    // sample outputs 1 time unit later, update the memory model at posedge.
    task automatic step(input logic st, input logic pcs, input logic [31:0] tgt, input logic rdy);
        logic [31:0] e;
        logic [31:0] dummy_a;
        int          dummy_d;
        @(negedge clk);
        rst       = 1'b1;
        stall     = st;
        pcsrc     = pcs;
        target    = tgt;
        req_ready = rdy;
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_data(addr_q[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
        s_rv    = req_valid;
        s_addr  = req_addr;
        s_iv    = instr_valid;
        s_pc    = pcf;
        s_p4    = pcp4;
        s_instr = instr;
        s_acc   = req_valid && rdy;
        // scoreboard: every pop must match the next expected PC
        if (sb_on && s_iv && !st && !pcs) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_pop actual_pc=%h required=no_pop (cycle %0d)", s_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", s_pc, e);
                chk("sb_instr", s_instr, mem_data(e));
                chk("sb_pcplus4", s_p4, e + 32'd4);
            end
        end
        @(posedge clk);
        if (rsp_valid) begin
            dummy_a = addr_q.pop_front();
            dummy_d = due_q.pop_front();
        end
        if (s_acc) begin
            addr_q.push_back(s_addr);
            due_q.push_back(cyc + mem_lat);
        end
        cyc++;
    endtask

    // Two reset edges; memory model is reset too. Outputs checked after the first.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        stall     = 1'b0;
        pcsrc     = 1'b0;
        target    = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        addr_q.delete();
        due_q.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_pcf", pcf, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pcplus4", pcp4, 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_bubble_cnt", bubble_cnt, 32'd0);
        chk("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
        @(posedge clk);
    endtask

    task automatic run_until_empty(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("sb_drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        int acc_cnt;
        stall = 1'b0; pcsrc = 1'b0; target = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0;

        // stall, exp_rv, exp_addr, exp_iv, exp_pc   (latency 1, ready 1)
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[11] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[12] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[13] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h1C};

        // ---- table: start-up stream and stall credit limit ----
        do_reset();
        mem_lat = 1;
        sb_on   = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].stall, 1'b0, 32'h0, 1'b1);
            chk($sformatf("v%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) chk($sformatf("v%0d_req_addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_instr_valid", i), 32'(s_iv), 32'(vecs[i].exp_iv));
            chk($sformatf("v%0d_pcf", i), s_pc, vecs[i].exp_iv ? vecs[i].exp_pc : 32'h0);
            chk($sformatf("v%0d_pcplus4", i), s_p4, vecs[i].exp_iv ? vecs[i].exp_pc + 32'd4 : 32'h0);
            chk($sformatf("v%0d_instr", i), s_instr, vecs[i].exp_iv ? mem_data(vecs[i].exp_pc) : 32'h0);
        end

        // ---- stall from reset: requests stop at 4, head holds 0x0 ----
        do_reset();
        mem_lat = 1;
        sb_on   = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (s_acc) acc_cnt++;
        end
        chk("stall_accepts", 32'(acc_cnt), 32'd4);
        chk("stall_req_valid", 32'(s_rv), 32'd0);
        chk("stall_head_valid", 32'(s_iv), 32'd1);
        chk("stall_head_pc", s_pc, 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        run_until_empty(30);

        // ---- redirect with 3 outstanding, latency 5 ----
        do_reset();
        mem_lat = 5;
        sb_on   = 1'b1;
        exp_q.push_back(32'h100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("rd_req_valid%0d", i), 32'(s_rv), 32'd1);
            chk($sformatf("rd_req_addr%0d", i), s_addr, 32'(i * 4));
        end
        step(1'b0, 1'b1, 32'h100, 1'b1);
        chk("rd_req_in_redirect", 32'(s_rv), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk($sformatf("rd_drain_req%0d", i), 32'(s_rv), 32'd0);
            chk($sformatf("rd_drain_iv%0d", i), 32'(s_iv), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd_resume_valid", 32'(s_rv), 32'd1);
        chk("rd_resume_addr", s_addr, 32'h100);
        run_until_empty(40);

        // ---- redirect coincident with a response, misaligned target ----
        do_reset();
        mem_lat = 1;
        sb_on   = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h203, 1'b1);
        chk("co_req_in_redirect", 32'(s_rv), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("co_iv_after", 32'(s_iv), 32'd0);
        chk("co_req_valid", 32'(s_rv), 32'd1);
        chk("co_req_addr", s_addr, 32'h200);
`ifdef FETCH_QUEUE_PERF_EN
        chk("co_redirect_cnt", redirect_cnt, 32'd1);
`endif
        run_until_empty(30);

        // ---- ready low for 3 cycles ----
        do_reset();
        mem_lat = 1;
        sb_on   = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("bp_valid%0d", i), 32'(s_rv), 32'd1);
            chk($sformatf("bp_addr%0d", i), s_addr, 32'h8);
        end
        run_until_empty(30);

        // ---- reset with 2 outstanding and 1 buffered ----
        do_reset();
        mem_lat = 2;
        sb_on   = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();
        mem_lat = 1;
        sb_on   = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rr_req_valid", 32'(s_rv), 32'd1);
        chk("rr_req_addr", s_addr, 32'h0);
        chk("rr_iv", 32'(s_iv), 32'd0);
        run_until_empty(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
